seg7_bcd_counter_scan: RTL and testbench
========================================

Name: seg7_bcd_counter_scan

Overview:
Parametrised N-digit BCD counter with a multiplexed seven-segment scan driver. It generalises the fixed 8-digit, per-digit-increment display to a true cascaded BCD counter. The counter supports up/down counting, parallel load, pause, leading-zero blanking, decimal points and selectable output polarity. It sits between board-level control inputs and the seven-segment digit/segment pins.

Parameters:
NUM_DIGITS, 8, number of displayed digits (1..8; need not be a power of 2)
SCAN_DIV, 100000, clk cycles per digit-scan step
TICK_DIV, 100000000, clk cycles per count tick (1 s at 100 MHz)
SEG_ACTIVE_LOW, 1, 1 = segment and digit-select outputs are active-low; 0 = active-high

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
load  in  1  load load_value into the counter this cycle
load_value  in  4*NUM_DIGITS  BCD digits; digit i is bits [4i+3:4i]
enable  in  1  1 = count on ticks; 0 = pause
up_down  in  1  1 = count up, 0 = count down
blank_lz  in  1  1 = blank leading zeros
dp_mask  in  NUM_DIGITS  decimal point on for digit i when bit i = 1
Bit  out  NUM_DIGITS  digit select, one digit active at a time
SEG  out  8  segments {dp,g,f,e,d,c,b,a}
count  out  4*NUM_DIGITS  current BCD value
wrap  out  1  one-cycle pulse on overflow or underflow

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - tick counter, scan counter, digit_sel = 0
  - count = 0, wrap = 0
  - Bit = all inactive
  - SEG = all segments off (8'hFF when SEG_ACTIVE_LOW=1, else 8'h00)
- Reset mid-operation: all state returns to the reset values on the next edge, regardless of any other input.
- Tick generator:
  - tick_cnt runs 0..TICK_DIV-1; tick = (tick_cnt == TICK_DIV-1), then tick_cnt returns to 0.
  - When enable=0, tick_cnt holds its value, so the tick phase is preserved across a pause.
- Counter update priority: rst > load > (tick & enable) > hold.
  - Load: each digit of load_value that is >9 is stored as 0. load does not disturb tick_cnt.
  - Simultaneous load and tick: load wins and that tick is discarded.
  - Up-count: ripple-carry BCD increment; a digit at 9 becomes 0 and carries into the next digit.
  - Down-count: ripple-borrow decrement; a digit at 0 becomes 9 and borrows from the next digit.
  - Wrap: all-9 up becomes all-0, and all-0 down becomes all-9. Either case raises wrap for exactly the cycle after that update.
  - count is registered; a change appears 1 cycle after the tick or load edge.
- Scan:
  - scan_cnt runs 0..SCAN_DIV-1. At its terminal value, digit_sel increments; after NUM_DIGITS-1 it returns to 0.
  - Bit and SEG are registered from digit_sel and count, giving 1 cycle of latency. Exactly one Bit bit is active after reset.
- Segment encoding (active-low form; active-high is the bitwise inverse):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
  - SEG[7] (dp) is active when dp_mask[digit_sel] = 1, and is independent of blanking.
- Leading-zero blanking (blank_lz=1): digit i is blanked (segments a–g off) when it and every more-significant digit are 0. Digit 0 is never blanked.
- Width rules: all BCD arithmetic is per 4-bit digit. There is no binary carry across digit boundaries.

Decomposition:
- Package seg7_pkg:
  - bcd_digit_t (4-bit)
  - SEG_CODE constant array for 0–9
  - SEG_BLANK constant
  - function seg_encode(digit, dp, active_low)
- Sub-module seg7_bcd_chain: the NUM_DIGITS BCD up/down counter, including load sanitising and the wrap pulse.
- Top level: tick divider, scan divider/mux, blanking and encoding.

Test Plan:
- Use NUM_DIGITS=4, SCAN_DIV=4, TICK_DIV=5 for every scenario.
- Reset: rst=1 for 2 cycles, release → count=0000, Bit=4'b1110 one cycle later, digit_sel advances every 4 cycles (0,1,2,3,0), wrap=0.
- Up carry: load 0199, enable=1, up_down=1 → after 1 tick count=0200; load 9999 + 1 tick → count=0000, wrap high for 1 cycle.
- Down borrow: load 1000, up_down=0, 1 tick → 0999; load 0000, 1 tick → 9999, wrap pulse.
- Load vs tick: assert load=1 with load_value=1A34 on the tick cycle → count=1034 (A sanitised to 0), no increment; next tick → 1035.
- Pause: enable=0 for 12 cycles mid-period → count unchanged; after re-enable, the next tick arrives after the remaining cycles of the preserved period.
- Display: count=0050, blank_lz=1, dp_mask=0010 → digit3 SEG=FF, digit2 SEG=FF, digit1 SEG=12 (5 with dp on), digit0 SEG=C0; with SEG_ACTIVE_LOW=0 every value is bitwise inverted.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types, seven-segment code table and encoder for the
//                BCD counter / scan display slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for digits 0..9, index 0 at LSB
    localparam logic [9:0][7:0] SEG_CODE = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Any non-decimal digit value encodes as a blank; callers use that to
    // blank a digit while keeping its decimal point.
    function automatic logic [7:0] seg_encode(
        input bcd_digit_t digit,
        input logic       dp,
        input logic       active_low
    );
        logic [7:0] code;
        code    = (digit <= 4'd9) ? SEG_CODE[digit] : SEG_BLANK;
        code[7] = ~dp;
        return active_low ? code : ~code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_bcd_chain.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_bcd_chain
//  Description : NUM_DIGITS cascaded BCD up/down counter with sanitised
//                parallel load and a one-cycle wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_bcd_chain
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    step,
    input  logic                    up_down,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap
);

    logic [4*NUM_DIGITS-1:0] r_count;
    logic                    r_wrap;
    logic [4*NUM_DIGITS-1:0] w_load_clean;
    logic [4*NUM_DIGITS-1:0] w_next;
    logic                    w_carry_out;

    always_comb begin
        w_load_clean = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_load_clean[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0
                                                                   : load_value[4*i +: 4];
        end
    end

    // Carry and borrow ripple through one shared flag; what leaves the top
    // digit is exactly the overflow/underflow condition.
    always_comb begin
        bcd_digit_t d;
        logic       carry;
        w_next = r_count;
        carry  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = r_count[4*i +: 4];
            if (carry) begin
                if (up_down) begin
                    if (d >= 4'd9) begin
                        w_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_next[4*i +: 4] = d + 4'd1;
                        carry            = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        w_next[4*i +: 4] = 4'd9;
                    end else begin
                        w_next[4*i +: 4] = d - 4'd1;
                        carry            = 1'b0;
                    end
                end
            end
        end
        w_carry_out = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clean;
            r_wrap  <= 1'b0;
        end else if (step) begin
            r_count <= w_next;
            r_wrap  <= w_carry_out;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: rtl/seg7_bcd_counter_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_bcd_counter_scan
//  Description : N-digit BCD counter with tick divider and a multiplexed
//                seven-segment scan driver (blanking, dp, polarity select).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_bcd_counter_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int TICK_DIV       = 100000000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    enable,
    input  logic                    up_down,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   Bit,
    output logic [7:0]              SEG,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap
);

    localparam int         TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int         SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int         SEL_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic       ACT_LOW  = (SEG_ACTIVE_LOW != 0);
    localparam logic [7:0] SEG_OFF  = ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] BIT_OFF = ACT_LOW ? '1 : '0;

    logic [TICK_W-1:0]     r_tick_cnt;
    logic [SCAN_W-1:0]     r_scan_cnt;
    logic [SEL_W-1:0]      r_digit_sel;
    logic [NUM_DIGITS-1:0] r_bit;
    logic [7:0]            r_seg;

    logic                  w_tick;
    logic                  w_step;
    logic                  w_scan_end;
    bcd_digit_t            w_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_blank;
    logic [NUM_DIGITS-1:0] w_onehot;
    bcd_digit_t            w_disp_digit;

    // ---------------------------------------------------------------- tick
    assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_step = w_tick & enable;

    // Held while paused so the remaining part of the period survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (enable) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    seg7_bcd_chain #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_chain (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .step       (w_step),
        .up_down    (up_down),
        .count      (count),
        .wrap       (wrap)
    );

    // ---------------------------------------------------------------- scan
    assign w_scan_end = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= '0;
        end else if (w_scan_end) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= (r_digit_sel == SEL_W'(NUM_DIGITS - 1)) ? '0
                                                                   : r_digit_sel + 1'b1;
        end else begin
            r_scan_cnt  <= r_scan_cnt + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
            assign w_digits[gi] = count[4*gi +: 4];
        end
    endgenerate

    // A digit is blanked while it and everything above it are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        w_blank  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (w_digits[i] == 4'd0);
            w_blank[i] = blank_lz & zero_run & (i != 0);
        end
    end

    assign w_onehot     = NUM_DIGITS'(1) << r_digit_sel;
    assign w_disp_digit = w_blank[r_digit_sel] ? 4'hF : w_digits[r_digit_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit <= BIT_OFF;
            r_seg <= SEG_OFF;
        end else begin
            r_bit <= ACT_LOW ? ~w_onehot : w_onehot;
            r_seg <= seg_encode(w_disp_digit, dp_mask[r_digit_sel], ACT_LOW);
        end
    end

    assign Bit = r_bit;
    assign SEG = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_bcd_counter_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_bcd_counter_scan
//  Description : Directed self-checking bench; two instances share stimulus,
//                one active-low and one active-high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_bcd_counter_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic        enable = 1'b0;
    logic        up_down = 1'b1;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_mask = 4'b0000;

    logic [3:0]  bit_lo, bit_hi;
    logic [7:0]  seg_lo, seg_hi;
    logic [15:0] count_lo, count_hi;
    logic        wrap_lo, wrap_hi;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] cap_lo [4];
    logic [7:0] cap_hi [4];
    logic [3:0] seen;

    always #5 clk = ~clk;

    seg7_bcd_counter_scan #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .TICK_DIV(5), .SEG_ACTIVE_LOW(1)
    ) u_dut_lo (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .blank_lz(blank_lz),
        .dp_mask(dp_mask), .Bit(bit_lo), .SEG(seg_lo),
        .count(count_lo), .wrap(wrap_lo)
    );

    seg7_bcd_counter_scan #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .TICK_DIV(5), .SEG_ACTIVE_LOW(0)
    ) u_dut_hi (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .blank_lz(blank_lz),
        .dp_mask(dp_mask), .Bit(bit_hi), .SEG(seg_hi),
        .count(count_hi), .wrap(wrap_hi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load_value = v;
        load       = 1'b1;
        step(1);
        load       = 1'b0;
    endtask

    // Walk a full scan frame and record each digit's segments by its select.
    task automatic capture();
        seen = 4'b0000;
        for (int k = 0; k < 20; k++) begin
            step(1);
            for (int d = 0; d < 4; d++) begin
                if (bit_lo == ~(4'b0001 << d)) begin
                    cap_lo[d] = seg_lo;
                    cap_hi[d] = seg_hi;
                    seen[d]   = 1'b1;
                end
            end
        end
        check("scan_all_digits", {28'd0, seen}, 32'h0000000F);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        step(2);
        check("rst_count", {16'd0, count_lo}, 32'h0000);
        check("rst_wrap", {31'd0, wrap_lo}, 32'h0);
        check("rst_bit_lo", {28'd0, bit_lo}, 32'hF);
        check("rst_seg_lo", {24'd0, seg_lo}, 32'hFF);
        check("rst_bit_hi", {28'd0, bit_hi}, 32'h0);
        check("rst_seg_hi", {24'd0, seg_hi}, 32'h00);
        rst = 1'b0;
        step(1);
        check("scan0_lo", {28'd0, bit_lo}, 32'hE);
        check("scan0_hi", {28'd0, bit_hi}, 32'h1);
        check("post_rst_count", {16'd0, count_lo}, 32'h0000);
        step(4); check("scan1", {28'd0, bit_lo}, 32'hD);
        step(4); check("scan2", {28'd0, bit_lo}, 32'hB);
        step(4); check("scan3", {28'd0, bit_lo}, 32'h7);
        step(4); check("scan_wrap", {28'd0, bit_lo}, 32'hE);

        // up carry
        up_down = 1'b1;
        do_load(16'h0199);
        check("load_0199", {16'd0, count_lo}, 32'h0199);
        enable = 1'b1;
        step(4); check("up_before_tick", {16'd0, count_lo}, 32'h0199);
        step(1); check("up_carry", {16'd0, count_lo}, 32'h0200);
        enable = 1'b0;
        do_load(16'h9999);
        enable = 1'b1;
        step(4); check("up_wrap_pre", {31'd0, wrap_lo}, 32'h0);
        step(1);
        check("up_wrap_count", {16'd0, count_lo}, 32'h0000);
        check("up_wrap_pulse", {31'd0, wrap_lo}, 32'h1);
        enable = 1'b0;
        step(1); check("up_wrap_end", {31'd0, wrap_lo}, 32'h0);

        // down borrow
        up_down = 1'b0;
        do_load(16'h1000);
        enable = 1'b1;
        step(5); check("down_borrow", {16'd0, count_lo}, 32'h0999);
        enable = 1'b0;
        do_load(16'h0000);
        enable = 1'b1;
        step(5);
        check("down_wrap_count", {16'd0, count_lo}, 32'h9999);
        check("down_wrap_pulse", {31'd0, wrap_lo}, 32'h1);
        enable = 1'b0;
        step(1); check("down_wrap_end", {31'd0, wrap_lo}, 32'h0);

        // load collides with tick
        up_down = 1'b1;
        enable  = 1'b1;
        step(4);
        do_load(16'h1A34);
        check("load_vs_tick", {16'd0, count_lo}, 32'h1034);
        step(4); check("after_load_hold", {16'd0, count_lo}, 32'h1034);
        step(1); check("after_load_tick", {16'd0, count_lo}, 32'h1035);

        // pause keeps tick phase
        step(2);
        enable = 1'b0;
        step(12); check("pause_hold", {16'd0, count_lo}, 32'h1035);
        enable = 1'b1;
        step(2); check("resume_pre", {16'd0, count_lo}, 32'h1035);
        step(1); check("resume_tick", {16'd0, count_lo}, 32'h1036);
        enable = 1'b0;

        // display
        do_load(16'h0050);
        blank_lz = 1'b1;
        dp_mask  = 4'b0010;
        step(2);
        capture();
        check("d3_lo", {24'd0, cap_lo[3]}, 32'hFF);
        check("d2_lo", {24'd0, cap_lo[2]}, 32'hFF);
        check("d1_lo", {24'd0, cap_lo[1]}, 32'h12);
        check("d0_lo", {24'd0, cap_lo[0]}, 32'hC0);
        check("d3_hi", {24'd0, cap_hi[3]}, 32'h00);
        check("d2_hi", {24'd0, cap_hi[2]}, 32'h00);
        check("d1_hi", {24'd0, cap_hi[1]}, 32'hED);
        check("d0_hi", {24'd0, cap_hi[0]}, 32'h3F);

        dp_mask = 4'b1000;
        step(1);
        capture();
        check("dp_on_blank_lo", {24'd0, cap_lo[3]}, 32'h7F);
        check("dp_on_blank_hi", {24'd0, cap_hi[3]}, 32'h80);

        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        step(1);
        capture();
        check("nolz_d3", {24'd0, cap_lo[3]}, 32'hC0);
        check("nolz_d2", {24'd0, cap_lo[2]}, 32'hC0);
        check("nolz_d1", {24'd0, cap_lo[1]}, 32'h92);
        check("nolz_d1_hi", {24'd0, cap_hi[1]}, 32'h6D);

        // reset dominates everything
        rst        = 1'b1;
        load       = 1'b1;
        load_value = 16'h4321;
        enable     = 1'b1;
        step(1);
        check("midrst_count", {16'd0, count_lo}, 32'h0000);
        check("midrst_bit", {28'd0, bit_lo}, 32'hF);
        check("midrst_seg", {24'd0, seg_lo}, 32'hFF);
        check("midrst_seg_hi", {24'd0, seg_hi}, 32'h00);
        rst    = 1'b0;
        load   = 1'b0;
        enable = 1'b0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
